// File: rtl/poly_tone_generator.sv
// Multi-channel square-wave tone generator: per-channel half-period dividers gated by
// note commands, a registered popcount mix and a first-order delta-sigma 1-bit output.
module poly_tone_generator #(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DIV_W    = 16,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned MIX_W    = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_chan,
  input  logic [DIV_W-1:0]    cmd_period,
  output logic [CHANNELS-1:0] chan_out,
  output logic [CHANNELS-1:0] gate_out,
  output logic [MIX_W-1:0]    mix_out,
  output logic                dsm_out
);

  typedef enum logic [1:0] {
    OP_OFF  = 2'b00,
    OP_ON   = 2'b01,
    OP_SETP = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  logic                ready_q;
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic [CHANNELS-1:0] gate_q, gate_d;
  logic [DIV_W-1:0]    per_q [CHANNELS];
  logic [DIV_W-1:0]    per_d [CHANNELS];
  logic [DIV_W-1:0]    cnt_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_d [CHANNELS];
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [CH_W-1:0]     acc_q, acc_d;
  logic                dsm_q, dsm_d;
  logic [MIX_W:0]      sum;
  logic                accept;

  always_comb begin
    accept = cmd_valid && ready_q;
    chan_d = chan_q;
    gate_d = gate_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!gate_q[i] || per_q[i] == '0) begin
        cnt_d[i]  = '0;
        chan_d[i] = 1'b0;
      end else if (cnt_q[i] >= per_q[i] - DIV_W'(1)) begin
        cnt_d[i]  = '0;
        chan_d[i] = ~chan_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + DIV_W'(1);
      end
      // A command overrides the free-running update (including a pending wrap).
      if (accept && 32'(cmd_chan) == i) begin
        case (op_e'(cmd_op))
          OP_ON: begin
            per_d[i]  = cmd_period;
            cnt_d[i]  = '0;
            chan_d[i] = |cmd_period;  // a zero period note stays silent
            gate_d[i] = 1'b1;
          end
          OP_OFF: begin
            gate_d[i] = 1'b0;
            chan_d[i] = 1'b0;
            cnt_d[i]  = '0;
          end
          OP_SETP: begin
            per_d[i]  = cmd_period;
            cnt_d[i]  = cnt_q[i];
            chan_d[i] = chan_q[i];
          end
          default: ;
        endcase
      end
    end

    mix_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      mix_d = mix_d + MIX_W'(chan_q[i]);
    end

    sum = (MIX_W+1)'(acc_q) + (MIX_W+1)'(mix_q);
    if (sum >= (MIX_W+1)'(CHANNELS)) begin
      dsm_d = 1'b1;
      acc_d = CH_W'(sum - (MIX_W+1)'(CHANNELS));
    end else begin
      dsm_d = 1'b0;
      acc_d = CH_W'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      chan_q  <= '0;
      gate_q  <= '0;
      mix_q   <= '0;
      acc_q   <= '0;
      dsm_q   <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        per_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      chan_q  <= chan_d;
      gate_q  <= gate_d;
      mix_q   <= mix_d;
      acc_q   <= acc_d;
      dsm_q   <= dsm_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cmd_ready = ready_q;
  assign chan_out  = chan_q;
  assign gate_out  = gate_q;
  assign mix_out   = mix_q;
  assign dsm_out   = dsm_q;

endmodule
